// File: rtl/tracer_pkg.sv
// Shared types and sizing helpers for the register-write tracer.
// The trace entry is packed as {pc, register number, data}.
package tracer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HALTED  = 2'd2
    } trace_state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_ENTRY_W = DEF_DATA_W + DEF_ADDR_W + DEF_DATA_W;

    function automatic int entry_width(input int data_w, input int addr_w);
        return data_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO for trace entries. A full FIFO still accepts a push when the
// same cycle pops; a pop on an empty FIFO is ignored.
module trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so stale entries never show after reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_write_tracer.sv
// Watches register-file writes from a core and logs {pc, reg, data} for selected
// registers into a trace FIFO; stops logging once the PC sits still (halt).
module reg_write_tracer
    import tracer_pkg::*;
#(
    parameter int                     DATA_W      = 32,
    parameter int                     ADDR_W      = 5,
    parameter int                     DEPTH       = 16,
    parameter logic [(2**ADDR_W)-1:0] WATCH_MASK  = 32'h0000_0002,
    parameter bit                     CHANGE_ONLY = 1'b0,
    parameter int                     HALT_CYCLES = 4,
    localparam int                    CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] pc,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              halted,
    output logic [1:0]        state
);

    localparam int NREG    = 2 ** ADDR_W;
    localparam int ENTRY_W = entry_width(DATA_W, ADDR_W);
    localparam int HC_W    = $clog2(HALT_CYCLES) + 1;
    localparam logic [HC_W-1:0] HALT_LIM = HC_W'(HALT_CYCLES - 1);
    localparam logic [HC_W-1:0] HALT_PRE = HC_W'(HALT_CYCLES - 2);

    trace_state_t      st;
    logic [DATA_W-1:0] shadow [NREG];
    logic [DATA_W-1:0] prev_pc;
    logic [HC_W-1:0]   halt_cnt;
    logic              pc_same;
    logic              halt_hit;
    logic              changed;
    logic              qualify;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign pc_same  = (pc == prev_pc);
    // This comparison is the (HALT_CYCLES-1)th in a row when the counter sits one short.
    assign halt_hit = pc_same && (halt_cnt >= HALT_PRE);
    assign changed  = (shadow[wr_addr] != wr_data);
    assign qualify  = (st == ST_CAPTURE) && reg_write && (wr_addr != '0)
                      && WATCH_MASK[wr_addr] && (!CHANGE_ONLY || changed);

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= ST_IDLE;
            halted <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (en) begin
                        st <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!en) begin
                        st <= ST_IDLE;
                    end else if (halt_hit) begin
                        st     <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!en) begin
                        st     <= ST_IDLE;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    st     <= ST_IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc  <= '0;
            halt_cnt <= '0;
        end else begin
            prev_pc <= pc;
            if (!pc_same) begin
                halt_cnt <= '0;
            end else if (halt_cnt != HALT_LIM) begin
                halt_cnt <= halt_cnt + 1'b1;
            end
        end
    end

    // Only watched registers are ever written, so the rest stay constant zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
            end
        end else if (qualify) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (qualify && fifo_full && !rd_en) begin
            overflow <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (qualify),
        .pop   (rd_en),
        .wdata ({pc, wr_addr, wr_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rd_valid = !fifo_empty;
    assign {rd_pc, rd_addr, rd_data} = head;

endmodule
